// File: rtl/haz_pkg.sv
// Shared types for the OTTER pipeline hazard controller: forwarding-mux selects
// and hazard FSM states.
package haz_pkg;

  typedef enum logic [1:0] {
    FWD_RF      = 2'b00,
    FWD_MEM_ALU = 2'b01,
    FWD_WB_ALU  = 2'b10,
    FWD_WB_LOAD = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    LOAD_WAIT = 2'b01,
    FLUSH     = 2'b10
  } haz_state_e;

endpackage

// File: rtl/haz_fwd_sel.sv
// Forwarding priority encoder for one EX source operand: the youngest producer
// (MEM, then WB) wins; x0 always reads the register file.
module haz_fwd_sel
  import haz_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_reg_write,
  input  logic            mem_mem_read,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_reg_write,
  input  logic            wb_mem_read,
  output fwd_sel_e        sel
);

  always_comb begin
    sel = FWD_RF;
    if (rs != '0) begin
      // A load in MEM has no data yet, so it falls through to the WB check.
      if (mem_reg_write && (mem_rd == rs) && !mem_mem_read) begin
        sel = FWD_MEM_ALU;
      end else if (wb_reg_write && (wb_rd == rs)) begin
        sel = wb_mem_read ? FWD_WB_LOAD : FWD_WB_ALU;
      end
    end
  end

endmodule

// File: rtl/haz_ctrl_unit.sv
// Pipeline hazard controller for the 5-stage OTTER core: forwarding, load-use
// stall, memory-wait hold and branch flush. Optional perf counters: HAZ_PERF_CNT_EN.
module haz_ctrl_unit
  import haz_pkg::*;
#(
  parameter int RA_W         = 5,
  parameter int BR_FLUSH     = 2,
  parameter int LOAD_TIMEOUT = 15,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [RA_W-1:0]  DE_RS1,
  input  logic [RA_W-1:0]  DE_RS2,
  input  logic             DE_RS1_USED,
  input  logic             DE_RS2_USED,
  input  logic [RA_W-1:0]  EX_RS1,
  input  logic [RA_W-1:0]  EX_RS2,
  input  logic [RA_W-1:0]  EX_RD,
  input  logic             EX_REG_WRITE,
  input  logic             EX_MEM_READ,
  input  logic [RA_W-1:0]  MEM_RD,
  input  logic             MEM_REG_WRITE,
  input  logic             MEM_MEM_READ,
  input  logic             MEM_RDATA_VALID,
  input  logic [RA_W-1:0]  WB_RD,
  input  logic             WB_REG_WRITE,
  input  logic             WB_MEM_READ,
  input  logic             BR_TAKEN,
  output fwd_sel_e         FWD_A_SEL,
  output fwd_sel_e         FWD_B_SEL,
  output logic             STALL,
  output logic             HOLD,
  output logic             FLUSH,
  output logic             ERR,
  output logic [CNT_W-1:0] PERF_STALL_CNT,
  output logic [CNT_W-1:0] PERF_HOLD_CNT,
  output logic [CNT_W-1:0] PERF_FLUSH_CNT
);

  localparam int LC_W = $clog2(LOAD_TIMEOUT + 1);
  localparam int FC_W = $clog2(BR_FLUSH + 1);
  localparam logic [LC_W-1:0] LC_MAX   = LC_W'(LOAD_TIMEOUT);
  localparam logic [FC_W-1:0] FC_FULL  = FC_W'(BR_FLUSH);
  localparam logic [FC_W-1:0] FC_FIRST = FC_W'(BR_FLUSH - 1);
  localparam logic [FC_W-1:0] FC_ONE   = FC_W'(1);

  haz_state_e      state, state_nxt;
  logic [LC_W-1:0] load_cnt, load_cnt_nxt;
  logic [FC_W-1:0] flush_cnt, flush_cnt_nxt;
  logic            err_q, err_nxt;
  fwd_sel_e        fwd_a, fwd_b;
  logic            load_use, hold_c, flush_c, stall_c, mem_wait;

  haz_fwd_sel #(.RA_W(RA_W)) u_fwd_a (
    .rs            (EX_RS1),
    .mem_rd        (MEM_RD),
    .mem_reg_write (MEM_REG_WRITE),
    .mem_mem_read  (MEM_MEM_READ),
    .wb_rd         (WB_RD),
    .wb_reg_write  (WB_REG_WRITE),
    .wb_mem_read   (WB_MEM_READ),
    .sel           (fwd_a)
  );

  haz_fwd_sel #(.RA_W(RA_W)) u_fwd_b (
    .rs            (EX_RS2),
    .mem_rd        (MEM_RD),
    .mem_reg_write (MEM_REG_WRITE),
    .mem_mem_read  (MEM_MEM_READ),
    .wb_rd         (WB_RD),
    .wb_reg_write  (WB_REG_WRITE),
    .wb_mem_read   (WB_MEM_READ),
    .sel           (fwd_b)
  );

  assign load_use = EX_MEM_READ && EX_REG_WRITE && (EX_RD != '0) &&
                    ((DE_RS1_USED && (DE_RS1 == EX_RD)) ||
                     (DE_RS2_USED && (DE_RS2 == EX_RD)));
  assign mem_wait = MEM_MEM_READ && !MEM_RDATA_VALID;

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    load_cnt_nxt  = '0;
    err_nxt       = err_q;
    hold_c        = 1'b0;
    flush_c       = 1'b0;
    case (state)
      RUN: begin
        if (mem_wait) begin
          hold_c    = 1'b1;
          state_nxt = LOAD_WAIT;
        end else if (BR_TAKEN) begin
          flush_c = 1'b1;
          if (BR_FLUSH > 1) begin
            state_nxt     = haz_pkg::FLUSH;
            flush_cnt_nxt = FC_FIRST;
          end
        end
      end
      LOAD_WAIT: begin
        if (MEM_RDATA_VALID) state_nxt = RUN;
        else                 hold_c    = 1'b1;
      end
      haz_pkg::FLUSH: begin
        // A memory wait freezes the remaining flush window rather than losing it.
        if (mem_wait) begin
          hold_c = 1'b1;
        end else begin
          flush_c = 1'b1;
          if (BR_TAKEN) begin
            flush_cnt_nxt = FC_FULL;
          end else if (flush_cnt <= FC_ONE) begin
            state_nxt     = RUN;
            flush_cnt_nxt = '0;
          end else begin
            flush_cnt_nxt = flush_cnt - FC_ONE;
          end
        end
      end
      default: state_nxt = RUN;
    endcase
    // Consecutive hold cycles, including the RUN cycle that starts the wait.
    if (hold_c) begin
      load_cnt_nxt = (load_cnt == LC_MAX) ? load_cnt : load_cnt + LC_W'(1);
      if (load_cnt_nxt == LC_MAX) err_nxt = 1'b1;
    end
    stall_c = load_use && !hold_c && !flush_c;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= RUN;
      load_cnt  <= '0;
      flush_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      load_cnt  <= load_cnt_nxt;
      flush_cnt <= flush_cnt_nxt;
      err_q     <= err_nxt;
    end
  end

  assign FWD_A_SEL = RST_N ? fwd_a : FWD_RF;
  assign FWD_B_SEL = RST_N ? fwd_b : FWD_RF;
  assign STALL     = RST_N && stall_c;
  assign HOLD      = RST_N && hold_c;
  assign FLUSH     = RST_N && flush_c;
  assign ERR       = RST_N && err_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] perf_stall, perf_hold, perf_flush;

  // Saturating event counters; they stick at all-ones instead of wrapping.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      perf_stall <= '0;
      perf_hold  <= '0;
      perf_flush <= '0;
    end else begin
      if (STALL && (perf_stall != '1)) perf_stall <= perf_stall + CNT_W'(1);
      if (HOLD  && (perf_hold  != '1)) perf_hold  <= perf_hold  + CNT_W'(1);
      if (FLUSH && (perf_flush != '1)) perf_flush <= perf_flush + CNT_W'(1);
    end
  end

  assign PERF_STALL_CNT = perf_stall;
  assign PERF_HOLD_CNT  = perf_hold;
  assign PERF_FLUSH_CNT = perf_flush;
`else
  assign PERF_STALL_CNT = '0;
  assign PERF_HOLD_CNT  = '0;
  assign PERF_FLUSH_CNT = '0;
`endif

endmodule

// File: tb/tb_haz_ctrl_unit.sv
// Directed bench for haz_ctrl_unit: expected output vectors are queued as each
// step is driven and checked against the DUT at the following falling edge.
module tb_haz_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        de_rs1_used, de_rs2_used, ex_reg_write, ex_mem_read;
  logic        mem_reg_write, mem_mem_read, mem_rdata_valid;
  logic        wb_reg_write, wb_mem_read, br_taken;
  logic [1:0]  fwd_a, fwd_b;
  logic        stall, hold, flush, err;
  logic [31:0] perf_stall, perf_hold, perf_flush;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  always #5 clk = ~clk;

  haz_ctrl_unit dut (
    .CLK             (clk),
    .RST_N           (rst_n),
    .DE_RS1          (de_rs1),
    .DE_RS2          (de_rs2),
    .DE_RS1_USED     (de_rs1_used),
    .DE_RS2_USED     (de_rs2_used),
    .EX_RS1          (ex_rs1),
    .EX_RS2          (ex_rs2),
    .EX_RD           (ex_rd),
    .EX_REG_WRITE    (ex_reg_write),
    .EX_MEM_READ     (ex_mem_read),
    .MEM_RD          (mem_rd),
    .MEM_REG_WRITE   (mem_reg_write),
    .MEM_MEM_READ    (mem_mem_read),
    .MEM_RDATA_VALID (mem_rdata_valid),
    .WB_RD           (wb_rd),
    .WB_REG_WRITE    (wb_reg_write),
    .WB_MEM_READ     (wb_mem_read),
    .BR_TAKEN        (br_taken),
    .FWD_A_SEL       (fwd_a),
    .FWD_B_SEL       (fwd_b),
    .STALL           (stall),
    .HOLD            (hold),
    .FLUSH           (flush),
    .ERR             (err),
    .PERF_STALL_CNT  (perf_stall),
    .PERF_HOLD_CNT   (perf_hold),
    .PERF_FLUSH_CNT  (perf_flush)
  );

  task automatic clr();
    de_rs1 = '0; de_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
    mem_rd = '0; wb_rd = '0;
    de_rs1_used = 0; de_rs2_used = 0; ex_reg_write = 0; ex_mem_read = 0;
    mem_reg_write = 0; mem_mem_read = 0; mem_rdata_valid = 0;
    wb_reg_write = 0; wb_mem_read = 0; br_taken = 0;
  endtask

  // Inputs are already driven; queue the expectation, compare at the falling
  // edge, then advance to just after the next rising edge.
  task automatic step(input string tag, input logic [1:0] a, input logic [1:0] b,
                      input logic st, input logic ho, input logic fl, input logic er);
    logic [7:0] got, e;
    string      t;
    exp_q.push_back({a, b, st, ho, fl, er});
    tag_q.push_back(tag);
    @(negedge clk);
    got = {fwd_a, fwd_b, stall, hold, flush, err};
    e   = exp_q.pop_front();
    t   = tag_q.pop_front();
    n_assert++;
    assert (got === e) else begin
      n_fail++;
      $error("FAIL %s: observed a/b/stall/hold/flush/err=%b expected %b", t, got, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] e);
    n_assert++;
    assert (got === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, e);
    end
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    #1;
    // Outputs are gated to zero during reset even with hazards presented.
    ex_rs1 = 5; mem_rd = 5; mem_reg_write = 1; br_taken = 1;
    de_rs2 = 7; de_rs2_used = 1; ex_rd = 7; ex_reg_write = 1; ex_mem_read = 1;
    step("reset_outputs", 2'b00, 2'b00, 0, 0, 0, 0);
    chk32("reset_perf_stall", perf_stall, 32'd0);
    chk32("reset_perf_flush", perf_flush, 32'd0);
    rst_n = 1'b1;
    clr();

    // Forwarding priority
    ex_rs1 = 5; mem_rd = 5; mem_reg_write = 1; wb_rd = 5; wb_reg_write = 1; wb_mem_read = 1;
    step("fwd_mem_wins", 2'b01, 2'b00, 0, 0, 0, 0);
    mem_reg_write = 0; ex_rs2 = 5;
    step("fwd_wb_load", 2'b11, 2'b11, 0, 0, 0, 0);
    wb_mem_read = 0;
    step("fwd_wb_alu", 2'b10, 2'b10, 0, 0, 0, 0);
    ex_rs1 = 0; wb_rd = 0; mem_rd = 0; mem_reg_write = 1;
    step("fwd_x0", 2'b00, 2'b00, 0, 0, 0, 0);
    clr();

    // Load-use stall: one cycle, then the bubble releases it
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 7; de_rs2 = 7; de_rs2_used = 1;
    step("loaduse_stall", 2'b00, 2'b00, 1, 0, 0, 0);
    ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0;
    mem_mem_read = 1; mem_rdata_valid = 1; mem_rd = 7; mem_reg_write = 1;
    step("loaduse_release", 2'b00, 2'b00, 0, 0, 0, 0);
    clr();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 7; de_rs2 = 0; de_rs2_used = 1;
    step("loaduse_rs2_x0", 2'b00, 2'b00, 0, 0, 0, 0);
    de_rs1 = 7; de_rs1_used = 0;
    step("loaduse_unused", 2'b00, 2'b00, 0, 0, 0, 0);
    clr();

    // Memory wait: hold 3 cycles, branch ignored while held
    mem_mem_read = 1; mem_rd = 3; mem_reg_write = 1;
    step("hold_1", 2'b00, 2'b00, 0, 1, 0, 0);
    br_taken = 1;
    step("hold_2_br", 2'b00, 2'b00, 0, 1, 0, 0);
    br_taken = 0;
    step("hold_3", 2'b00, 2'b00, 0, 1, 0, 0);
    mem_rdata_valid = 1;
    step("hold_valid", 2'b00, 2'b00, 0, 0, 0, 0);
    clr();
    step("hold_idle", 2'b00, 2'b00, 0, 0, 0, 0);

    // Branch flush, re-armed by a second branch in its 2nd cycle
    br_taken = 1;
    step("flush_c0", 2'b00, 2'b00, 0, 0, 1, 0);
    step("flush_c1_rebr", 2'b00, 2'b00, 0, 0, 1, 0);
    br_taken = 0;
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 9; de_rs1 = 9; de_rs1_used = 1;
    step("flush_c2_nostall", 2'b00, 2'b00, 0, 0, 1, 0);
    clr();
    step("flush_c3", 2'b00, 2'b00, 0, 0, 1, 0);
    step("flush_done", 2'b00, 2'b00, 0, 0, 0, 0);

`ifdef HAZ_PERF_CNT_EN
    chk32("perf_stall", perf_stall, 32'd1);
    chk32("perf_hold", perf_hold, 32'd3);
    chk32("perf_flush", perf_flush, 32'd4);
`else
    chk32("perf_stall_off", perf_stall, 32'd0);
    chk32("perf_hold_off", perf_hold, 32'd0);
    chk32("perf_flush_off", perf_flush, 32'd0);
`endif

    // RS1 load-use, then a lone branch that outranks a simultaneous load-use
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 4; de_rs1 = 4; de_rs1_used = 1;
    step("loaduse_rs1", 2'b00, 2'b00, 1, 0, 0, 0);
    br_taken = 1;
    step("lone_br_c0", 2'b00, 2'b00, 0, 0, 1, 0);
    clr();
    step("lone_br_c1", 2'b00, 2'b00, 0, 0, 1, 0);
    step("lone_br_done", 2'b00, 2'b00, 0, 0, 0, 0);

    // Load timeout: ERR appears after 15 hold cycles and is sticky
    mem_mem_read = 1; mem_rd = 3; mem_reg_write = 1;
    for (int k = 1; k <= 15; k++) step("timeout_wait", 2'b00, 2'b00, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) step("timeout_err", 2'b00, 2'b00, 0, 1, 0, 1);
    rst_n = 1'b0;
    step("reset_mid_wait", 2'b00, 2'b00, 0, 0, 0, 0);
    rst_n = 1'b1;
    clr();
    step("after_reset_run", 2'b00, 2'b00, 0, 0, 0, 0);
    chk32("after_reset_perf_hold", perf_hold, 32'd0);

    // Reset mid-flush aborts the remaining window
    br_taken = 1;
    step("rst_flush_c0", 2'b00, 2'b00, 0, 0, 1, 0);
    br_taken = 0;
    rst_n = 1'b0;
    step("rst_flush_in_reset", 2'b00, 2'b00, 0, 0, 0, 0);
    rst_n = 1'b1;
    step("rst_flush_aborted", 2'b00, 2'b00, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
